// File: rtl/cmd_tx.sv
// SD CMD line transmitter: serializes a 48-bit command frame with on-the-fly CRC7, state updates on negedge clk.
// Optional preamble of PRE_CYCLES ones before the start bit is enabled by defining CMDTX_PREAMBLE_EN.
module cmd_tx #(
  parameter int GAP_CYCLES = 2,
  parameter int PRE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        scmdout,
  output logic        oe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef CMDTX_PREAMBLE_EN
    S_PRE  = 3'd1,
`endif
    S_SEND = 3'd2,
    S_CRC  = 3'd3,
    S_ENDB = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  localparam logic [5:0] PRE_LAST = 6'(PRE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [39:0] r_shift;
  logic [6:0]  r_crc;
  logic [5:0]  r_cnt;
  logic [3:0]  r_gap;
  logic        r_done;
  logic        w_oe;
  logic        w_sout;

  // Serial CRC7, polynomial x^7 + x^3 + 1
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_oe   = 1'b0;
    w_sout = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef CMDTX_PREAMBLE_EN
          w_next = S_PRE;
`else
          w_next = S_SEND;
`endif
        end
      end
`ifdef CMDTX_PREAMBLE_EN
      S_PRE: begin
        w_oe = 1'b1;
        if (r_cnt == PRE_LAST) w_next = S_SEND;
      end
`endif
      S_SEND: begin
        w_oe   = 1'b1;
        w_sout = r_shift[39];
        if (r_cnt == 6'd39) w_next = S_CRC;
      end
      S_CRC: begin
        w_oe   = 1'b1;
        w_sout = r_crc[3'd6 - r_cnt[2:0]];
        if (r_cnt == 6'd6) w_next = S_ENDB;
      end
      S_ENDB: begin
        w_oe   = 1'b1;
        w_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs follow the state register directly, so an async reset clears them at once
  assign oe      = w_oe;
  assign scmdout = w_sout;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_crc   <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_ENDB);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift <= {1'b0, 1'b1, cmd_index, cmd_arg};
            r_crc   <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
          end
        end
`ifdef CMDTX_PREAMBLE_EN
        S_PRE: begin
          r_cnt <= (r_cnt == PRE_LAST) ? 6'd0 : r_cnt + 6'd1;
        end
`endif
        S_SEND: begin
          // CRC absorbs the bit that was on the line during the interval just ending
          r_crc   <= crc7_step(r_crc, r_shift[39]);
          r_shift <= {r_shift[38:0], 1'b0};
          r_cnt   <= (r_cnt == 6'd39) ? 6'd0 : r_cnt + 6'd1;
        end
        S_CRC: begin
          r_cnt <= r_cnt + 6'd1;
        end
        S_ENDB: begin
          r_gap <= '0;
        end
        S_GAP: begin
          r_gap <= r_gap + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_tx.sv
// Directed bench for cmd_tx: checks serial frames against known SD command frames.
module tb_cmd_tx;

`ifdef CMDTX_PREAMBLE_EN
  localparam int PRE = 8;
`else
  localparam int PRE = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        scmdout;
  logic        oe;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  cmd_tx #(.GAP_CYCLES(2), .PRE_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .scmdout   (scmdout),
    .oe        (oe),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Captures one frame starting at the first sample with oe=1; optionally disturbs inputs mid-frame.
  task automatic frame_check(input logic [47:0] exp, input string tag, input bit disturb);
    logic [47:0] got;
    int          t;
    int          oecnt;
    int          ones;
    got   = '0;
    t     = 0;
    oecnt = 0;
    ones  = 0;
    #1;
    while (oe !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    chk({tag, "_oe_rise"}, {63'd0, oe}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    for (int i = 0; i < PRE + 48; i++) begin
      if (i < PRE) ones += (scmdout === 1'b1) ? 1 : 0;
      else got[47 - (i - PRE)] = scmdout;
      oecnt += (oe === 1'b1) ? 1 : 0;
      if (disturb && i == 20) begin
        cmd_arg   = ~cmd_arg;
        cmd_index = ~cmd_index;
        start     = 1'b1;
      end
      if (disturb && i == 21) start = 1'b0;
      step();
    end
    chk({tag, "_frame"}, {16'd0, got}, {16'd0, exp});
    chk({tag, "_oe_len"}, 64'(oecnt), 64'(PRE + 48));
    if (PRE > 0) chk({tag, "_preamble"}, 64'(ones), 64'(PRE));
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_oe_off"}, {63'd0, oe}, 64'd0);
    chk({tag, "_idle_line"}, {63'd0, scmdout}, 64'd1);
    chk({tag, "_busy_gap"}, {63'd0, busy}, 64'd1);
    step();
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    cmd_index = 6'd0;
    cmd_arg   = 32'd0;
    step();
    step();
    chk("rst_oe", {63'd0, oe}, 64'd0);
    chk("rst_sout", {63'd0, scmdout}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk);
    reset = 1'b1;

    // CMD0
    @(posedge clk);
    start = 1'b1; cmd_index = 6'd0; cmd_arg = 32'h0;
    @(posedge clk);
    start = 1'b0;
    frame_check(48'h400000000095, "cmd0", 1'b0);
    step();
    step();
    chk("cmd0_busy_end", {63'd0, busy}, 64'd0);

    // CMD8
    @(posedge clk);
    start = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h000001AA;
    @(posedge clk);
    start = 1'b0;
    frame_check(48'h48000001AA87, "cmd8", 1'b0);
    repeat (3) step();

    // CMD17 with arg/index changes and a start pulse mid-frame
    @(posedge clk);
    start = 1'b1; cmd_index = 6'd17; cmd_arg = 32'h0;
    @(posedge clk);
    start = 1'b0;
    frame_check(48'h510000000055, "cmd17", 1'b1);
    repeat (6) step();
    chk("cmd17_no_queue_oe", {63'd0, oe}, 64'd0);
    chk("cmd17_no_queue_busy", {63'd0, busy}, 64'd0);

    // CMD55 with start held high: back-to-back frames
    @(posedge clk);
    start = 1'b1; cmd_index = 6'd55; cmd_arg = 32'h0;
    @(posedge clk);
    frame_check(48'h770000000065, "cmd55a", 1'b0);
    step();
    chk("cmd55_gap_oe", {63'd0, oe}, 64'd0);
    step();
    if (PRE == 0) chk("cmd55_restart_bit", {63'd0, scmdout}, 64'd0);
    chk("cmd55_restart_oe", {63'd0, oe}, 64'd1);
    start = 1'b0;
    frame_check(48'h770000000065, "cmd55b", 1'b0);
    repeat (6) step();

    // Reset asserted mid-frame
    @(posedge clk);
    start = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h000001AA;
    @(posedge clk);
    start = 1'b0;
    repeat (PRE + 20) step();
    chk("mid_oe_before", {63'd0, oe}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_oe", {63'd0, oe}, 64'd0);
    chk("mid_rst_sout", {63'd0, scmdout}, 64'd1);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    start = 1'b1; cmd_index = 6'd0; cmd_arg = 32'h0;
    @(posedge clk);
    start = 1'b0;
    frame_check(48'h400000000095, "cmd0_after_rst", 1'b0);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
